// File: rtl/data_memory_unit_pkg.sv
// Shared sizing for the memory-stage data RAM: word width, default depth and
// the clock period used by unit benches.
package data_memory_unit_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned DMEM_DEPTH = 128;
  localparam int unsigned CYCLE      = 10;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/data_memory_unit.sv
// Byte-addressed, word-wide data RAM. Loads are combinational, stores land on
// the rising clock edge, and an asynchronous active-low reset zeroes the array.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int unsigned WORD  = WORD_W,
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_write,
  input  logic            mem_read,
  input  logic [WORD-1:0] address,
  input  logic [WORD-1:0] write_data,
  output logic [WORD-1:0] read_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WORD-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] index;

  // Byte offset and bits above the array span are dropped: aligned, wrapping.
  assign index = address[IDX_W+2:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[WORD-1:IDX_W+3], address[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[index] <= write_data;
    end
  end

  always_comb begin
    read_data = '0;
    if (mem_read && rst_n) begin
      read_data = mem[index];
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: stimulus pushes expected load data,
// a negedge monitor pops and compares against read_data.
module tb_data_memory_unit;
  import data_memory_unit_pkg::*;

  localparam int unsigned DEPTH = DMEM_DEPTH;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  data_memory_unit #(.WORD(64), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #(CYCLE/2) clk = ~clk;

  logic [63:0] model [DEPTH];
  logic [63:0] exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int unsigned word_of(input logic [63:0] a);
    return int'((a / 8) % DEPTH);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
  endtask

  // One cycle of stimulus: drive just after the rising edge, predict the value
  // seen at the following falling edge, then let the store land next edge.
  task automatic step(input logic rd, input logic wr,
                      input logic [63:0] a, input logic [63:0] wd);
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    address    = a;
    write_data = wd;
    exp_q.push_back((rd && rst_n) ? model[word_of(a)] : 64'd0);
    if (wr && rst_n) model[word_of(a)] = wd;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (read_data !== e) begin
        miscompares++;
        $display("FAIL read_data vec %0d addr=%h rd=%0b wr=%0b: got %h expected %h",
                 vectors, address, mem_read, mem_write, read_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd;
    rst_n      = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = 64'd0;
    write_data = 64'd0;
    clear_model();

    // Loads during reset read zero even with read enabled; writes are dropped.
    step(1'b1, 1'b0, 64'd2, 64'd0);
    step(1'b1, 1'b1, 64'd2, 64'hFFFF);

    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_write = 1'b0;

    step(1'b1, 1'b0, 64'd2, 64'd0);
    step(1'b1, 1'b0, 64'd2, 64'd0);
    step(1'b0, 1'b1, 64'd2, 64'd1);
    step(1'b1, 1'b0, 64'd0, 64'd0);
    step(1'b1, 1'b0, 64'd7, 64'd0);

    step(1'b0, 1'b1, 64'd8,  64'hDEADBEEF_CAFEF00D);
    step(1'b0, 1'b1, 64'd16, 64'd1);
    step(1'b1, 1'b0, 64'd8,  64'd0);
    step(1'b1, 1'b0, 64'd16, 64'd0);

    step(1'b1, 1'b0, 64'(DEPTH * 8), 64'd0);
    step(1'b1, 1'b0, 64'hFFFF_0000_0000_0000 | 64'(DEPTH * 8) | 64'd5, 64'd0);

    step(1'b0, 1'b1, 64'd40, 64'd5);
    step(1'b1, 1'b1, 64'd40, 64'd9);
    step(1'b1, 1'b0, 64'd40, 64'd0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1)
        a = {$urandom(), $urandom()};
      else
        a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      wd = {$urandom(), $urandom()};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, wd);
    end

    // Make sure word 1 is nonzero, then drop reset between edges while reading.
    step(1'b0, 1'b1, 64'd8, 64'h1234_5678_9ABC_DEF0);
    step(1'b1, 1'b0, 64'd8, 64'd0);
    @(posedge clk);
    #1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    address   = 64'd8;
    write_data = 64'hAAAA;
    #2 rst_n = 1'b0;
    clear_model();
    exp_q.push_back(64'd0);

    step(1'b1, 1'b1, 64'd16, 64'h5555);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_write = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 64'(i * 8), 64'd0);
    end

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending expected, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Data memory for the ARMv8 pipeline's memory stage (DUT module name `data_memory`). It is a word-wide RAM addressed by byte address; load instructions read it combinationally and store instructions write it on the rising clock edge. A simulation-only `oscillator` provides the free-running clock that drives it in unit benches.

## Interface
Parameters:
- `WORD`, default 64, data and address width in bits. It comes from the shared `` `WORD `` define.
- `DEPTH`, default 128, number of 64-bit words. Must be a power of two.

Ports:
- `clk`, input, 1, system clock. Rising edge is active.
- `rst_n`, input, 1, reset. One clock; reset is asynchronous and active-low.
- `mem_write`, input, 1, store enable. Sampled at the rising edge of `clk`.
- `mem_read`, input, 1, load enable. Gates `read_data` combinationally.
- `address`, input, `WORD`, byte address.
- `write_data`, input, `WORD`, store data.
- `read_data`, output, `WORD`, load data.

## Operation
- Storage: array of `DEPTH` words, each `WORD` bits wide.
- Word index = `address[$clog2(DEPTH)+2:3]`.
  - Bits [2:0] are ignored, so all accesses are aligned to 8 bytes.
  - Upper bits are ignored, so addresses wrap modulo `DEPTH*8`.
- Write: on rising `clk` with `rst_n`=1 and `mem_write`=1, `mem[index] <= write_data`. This is a full-word write with no byte enables.
- Read: `read_data = mem_read ? mem[index] : 0`. It is purely combinational.
- `mem_read` and `mem_write` both 1:
  - Before the edge, `read_data` shows the old contents.
  - After the edge, `read_data` shows `write_data`.
  - No bypass is provided.
- `mem_write`=0: contents are held indefinitely.
- Reset: asserting `rst_n`=0 immediately clears every word to 0.
  - While reset is asserted, `read_data` is 0 regardless of `mem_read`.
  - Writes are ignored while reset is asserted.
  - Reset asserted mid-operation discards any in-progress store; the array ends up all-zero.
- No X propagation: once reset has been asserted, every read returns a defined value.

## Timing
- Read latency: 0 cycles (combinational path from `address`/`mem_read` to `read_data`).
- Write latency: 1 edge. The new value is visible on `read_data` in the same cycle, just after the rising edge.
- `rst_n` release: takes effect asynchronously. The first write can happen on the first rising edge with `rst_n`=1.
- `oscillator` (simulation only):
  - Output `clk` starts at 0 at time 0.
  - Toggles every `` `CYCLE``/2, giving period `` `CYCLE``.
  - Has no inputs and no reset.

## Structure
- `definitions.vh` (shared) holds:
  - `` `WORD `` = 64
  - `` `CYCLE `` (clock period in time units)
  - `` `DMEM_DEPTH `` (default for `DEPTH`)
- `data_memory` is a single module with no sub-modules. The array plus a write process and a read assign are sufficient.
- `oscillator` is a separate, non-synthesizable module. It is shared by all stage benches.

## Test plan
- Reset, then `address`=2, `mem_read`=1, `mem_write`=0 for 2 cycles -> `read_data`=0 throughout.
- Then `mem_read`=0, `mem_write`=1, `write_data`=1 -> `read_data`=0 while read is off. Then with `mem_read`=1 at `address`=0 and at `address`=7 -> 1 (same word as address 2).
- Write `0xDEADBEEF_CAFEF00D` at `address`=8, then `0x1` at `address`=16 -> reading 8 returns `0xDEADBEEF_CAFEF00D` and reading 16 returns 1.
- `address`=`DEPTH*8` -> aliases word 0: the read returns word 0's contents.
- Read and write the same word in the same cycle (old=5, new=9) -> `read_data`=5 before the edge and 9 after it.
- Assert `rst_n`=0 mid-cycle after writes -> `read_data` drops to 0 without waiting for a clock edge. After release, every word previously written reads 0.
